// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder data-memory responder.
package mem_resp_pkg;

    localparam int STATE_W          = 2;
    localparam int RESP_RDATA_STORE = 0;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_WIDTH word storage: asynchronous clear, synchronous write, combinational read.
module mem_resp_array #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // The whole array clears on reset, so stores made before a reset are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle load/store responder with fixed LATENCY, one transaction in flight.
// Optional misaligned-access check enabled by defining MEM_RESP_ALIGN_CHK_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_misalign;
    logic                  w_accept;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr;

    // Byte address to word index; upper bits are dropped so accesses wrap.
    assign w_idx         = req_addr[IDX_W:1];
    assign w_unused_addr = ^{req_addr[ADDR_WIDTH-1:IDX_W+1], req_addr[0]};

`ifdef MEM_RESP_ALIGN_CHK_EN
    assign w_misalign = req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_we     = w_accept && req_wr && !w_misalign;

    mem_resp_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (req_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Response payload is captured at acceptance and held until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_misalign;
            if (w_misalign || req_wr) begin
                r_rdata <= DATA_WIDTH'(RESP_RDATA_STORE);
            end else begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, corner sequences, randomized run vs. word-array model.
module tb_mem_responder;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 256;
    localparam int LATENCY    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_WIDTH-1:0] model [DEPTH];

    typedef struct {
        string                 name;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] exp_rdata;
        logic                  exp_err;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction; stall = cycles resp_ready is held low once resp_valid rises.
    task automatic do_txn(input string nm, input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [DATA_WIDTH-1:0] wdata, input logic [DATA_WIDTH-1:0] exp_rd,
                          input logic exp_err, input int stall);
        int k;
        @(negedge clk);
        chk({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = ADDR_WIDTH'($urandom);
        req_wdata = DATA_WIDTH'($urandom);
        k = 1;
        while (!resp_valid && k < LATENCY + 6) begin
            chk({nm, ".req_ready_busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        if (!resp_valid) begin
            chk({nm, ".resp_timeout"}, 32'(resp_valid), 32'd1);
            resp_ready = 1'b0;
            return;
        end
        chk({nm, ".latency"}, 32'(k), 32'(LATENCY));
        chk({nm, ".rdata"}, 32'(resp_rdata), 32'(exp_rd));
        chk({nm, ".err"}, 32'(resp_err), 32'(exp_err));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({nm, ".stall_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, ".stall_rdata"}, 32'(resp_rdata), 32'(exp_rd));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, ".valid_drop"}, 32'(resp_valid), 32'd0);
        chk({nm, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wd;
        logic [DATA_WIDTH-1:0] exp_rd;
        logic                  exp_err;
        int                    idx;
        int                    guard;

        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        #12;
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.resp_rdata", 32'(resp_rdata), 32'd0);
        chk("reset.resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{"load_0010",   1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{"store_beef",  1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0};
        vecs[2] = '{"load_beef",   1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0};
        vecs[3] = '{"store_wrap",  1'b1, 16'h0202, 16'h1234, 16'h0000, 1'b0};
        vecs[4] = '{"load_wrap",   1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0};
`ifdef MEM_RESP_ALIGN_CHK_EN
        vecs[5] = '{"load_misal",  1'b0, 16'h0021, 16'h0000, 16'h0000, 1'b1};
        vecs[6] = '{"store_misal", 1'b1, 16'h0021, 16'hAAAA, 16'h0000, 1'b1};
        vecs[7] = '{"load_after",  1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0};
`else
        vecs[5] = '{"load_misal",  1'b0, 16'h0021, 16'h0000, 16'hBEEF, 1'b0};
        vecs[6] = '{"store_misal", 1'b1, 16'h0021, 16'hAAAA, 16'h0000, 1'b0};
        vecs[7] = '{"load_after",  1'b0, 16'h0020, 16'h0000, 16'hAAAA, 1'b0};
`endif
        foreach (vecs[i]) begin
            do_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        // Backpressure: restore 0xBEEF, then stall a load for 10 cycles with a competing request.
        do_txn("restore_beef", 1'b1, 16'h0020, 16'hBEEF, 16'h0000, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0020; req_wdata = '0; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_wr = 1'b1; req_wdata = 16'h0BAD;
        guard = 0;
        while (!resp_valid && guard < LATENCY + 6) begin
            @(negedge clk);
            guard++;
        end
        chk("bp.resp_valid_rise", 32'(resp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            chk("bp.hold_valid", 32'(resp_valid), 32'd1);
            chk("bp.hold_rdata", 32'(resp_rdata), 32'hBEEF);
            chk("bp.req_blocked", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("bp.one_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("bp.still_idle", 32'(resp_valid), 32'd0);
        do_txn("bp.no_store", 1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1'b0, 0);

        // Reset during WAIT after a store: no response, array cleared.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h5555; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < LATENCY + 3; c++) begin
            chk("rst_mid.no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b0;
        do_txn("rst_mid.load", 1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b0, 0);

        // Randomized traffic against a plain word-array model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int t = 0; t < 80; t++) begin
            wr   = 1'($urandom);
            addr = ADDR_WIDTH'($urandom_range(0, 16'h00FF));
            if ($urandom_range(0, 3) == 0) addr = ADDR_WIDTH'($urandom);
            wd   = DATA_WIDTH'($urandom);
            idx  = int'(addr / 2) % DEPTH;
            exp_err = 1'b0;
`ifdef MEM_RESP_ALIGN_CHK_EN
            exp_err = addr[0];
`endif
            if (exp_err || wr) begin
                exp_rd = '0;
            end else begin
                exp_rd = model[idx];
            end
            if (wr && !exp_err) model[idx] = wd;
            do_txn("rand", wr, addr, wd, exp_rd, exp_err, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle data-memory responder. It serves load/store requests from the CPU's memory stage over a valid/ready request channel and a valid/ready response channel.
- It replaces the single-cycle data memory once the pipeline supports stalls, and introduces a configurable fixed access latency.
- Exactly one transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 16, word width.
- DEPTH, 256, number of words stored; must be a power of 2.
- LATENCY, 4, cycles from the request-acceptance edge to resp_valid; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  byte address; word index = req_addr[log2(DEPTH):1].
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU accepts the response.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores.
- resp_err  output  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - All DEPTH words cleared to 0.
  - Reset asserted mid-transaction aborts it; no response is ever produced.
  - A store already committed before the reset is lost, because the array is cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted and the access is performed at that same edge.
  - Store: mem[idx] <= req_wdata; resp_rdata <= 0.
  - Load: resp_rdata <= mem[idx], with the pre-write value at that edge.
  - Next state: if LATENCY==1, go to RESP; otherwise go to WAIT with cnt <= LATENCY-2.
- WAIT:
  - req_ready=0 and resp_valid=0.
  - If cnt==0, go to RESP; otherwise cnt <= cnt-1.
- RESP:
  - req_ready=0 and resp_valid=1.
  - resp_rdata and resp_err are held stable while resp_valid=1.
  - On an edge with resp_ready=1, go to IDLE; resp_valid drops in the next cycle.
  - resp_ready=0 stalls indefinitely with no data change.
- Latency: resp_valid is first high in the LATENCY-th cycle after the acceptance edge.
- Throughput: at most one transaction per LATENCY+1 cycles. A request cannot be accepted in the same cycle as a response handshake.
- Request inputs are sampled only at the acceptance edge. Changes while req_ready=0 are ignored.
- resp_ready asserted outside RESP is ignored.
- Address bits above log2(DEPTH) are ignored, so accesses wrap modulo DEPTH words.
- Counter width is clog2(LATENCY); no counter overflow is possible.

Optional Feature:
- Macro: MEM_RESP_ALIGN_CHK_EN.
- Defined: a request with req_addr[0]=1 is accepted and timed normally.
  - No array read or write is performed.
  - The response carries resp_err=1 and resp_rdata=0.
  - Aligned requests return resp_err=0.
- Undefined: req_addr[0] is ignored; resp_err is tied to 0.

Decomposition:
- Package mem_resp_pkg:
  - state enum (IDLE, WAIT, RESP);
  - state encoding width;
  - the RESP_RDATA_STORE constant (0).
- Sub-module mem_resp_array: DEPTH x DATA_WIDTH storage.
  - Asynchronous clear.
  - Synchronous write port.
  - Combinational read port.
  - Instantiated once. The FSM, counter and response registers stay in the top module.

Test Plan:
- Reset then load: LATENCY=4, load addr 0x0010 with resp_ready=1.
  - req_ready=0 for 4 cycles; resp_valid high in cycle 4 after acceptance.
  - resp_rdata=0x0000; back to IDLE one cycle later.
- Store then load: store 0xBEEF to 0x0020, then load 0x0020 → resp_rdata=0xBEEF.
  - The store response has resp_rdata=0x0000.
- Backpressure: hold resp_ready=0 for 10 cycles during a load of 0xBEEF.
  - resp_valid stays 1 and resp_rdata stays 0xBEEF; req_valid asserted meanwhile is not accepted.
  - Releasing resp_ready completes exactly one response.
- Wrap: DEPTH=256, store 0x1234 to 0x0202, then load 0x0002 → 0x1234.
- Reset mid-operation: assert rst_n=0 during WAIT after a store of 0x5555 to 0x0030.
  - resp_valid never asserts.
  - After reset, req_ready=1 and a load of 0x0030 returns 0x0000.
- Misaligned access with MEM_RESP_ALIGN_CHK_EN defined: load 0x0021 → resp_err=1, resp_rdata=0.
  - A store to 0x0021 leaves 0x0020 unchanged.
  - With the macro undefined, load 0x0021 returns mem[0x0020] with resp_err=0.
